stall_ctrl: RTL and testbench

Hazard and stall controller for the five-stage pipeline. Compares the register-read demand (Tuse) of the instruction in D against the pending results (Tnew) of the instructions in E and M. Sequences the multi-cycle multiply/divide unit through an internal busy counter. Drives the freeze of PC and IF/ID and the bubble-insert (`clr`) of the ID/EX register.

---
 rtl/stall_ctrl.sv | 92 +++++++++
 tb/tb_stall_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// Hazard and stall controller: register Tuse/Tnew interlock plus
// multiply/divide busy sequencing; drives PC/IF-ID freeze and ID/EX bubble.
module stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Interrupt,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic [1:0] TuseRs_D,
    input  logic [1:0] TuseRt_D,
    input  logic [4:0] WriteAddr_E,
    input  logic [1:0] Tnew_E,
    input  logic [4:0] WriteAddr_M,
    input  logic [1:0] Tnew_M,
    input  logic       MDStart_E,
    input  logic       MDIsDiv_E,
    input  logic       MDUse_D,
    output logic       stall,
    output logic       clr,
    output logic       busy,
    output logic [3:0] mdCount
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } md_state_t;

    localparam logic [3:0] L_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] L_DIV  = 4'(DIV_CYCLES);

    md_state_t  r_state;
    logic [3:0] r_count;

    logic       w_start;
    logic [3:0] w_load;
    logic       w_rs_haz;
    logic       w_rt_haz;
    logic       w_md_haz;

    // An operand stalls only if a producer still needs more cycles
    // than the consumer can wait; equal values are covered by forwarding.
    function automatic logic f_haz(
        input logic [4:0] addr,
        input logic [1:0] tuse,
        input logic [4:0] wa_e,
        input logic [1:0] tnew_e,
        input logic [4:0] wa_m,
        input logic [1:0] tnew_m
    );
        logic w_e;
        logic w_m;
        w_e = (addr == wa_e) && (tuse < tnew_e);
        w_m = (addr == wa_m) && (tuse < tnew_m);
        return (addr != 5'd0) && (tuse != 2'd3) && (w_e || w_m);
    endfunction

    assign w_start  = MDStart_E & ~Interrupt;
    assign w_load   = MDIsDiv_E ? L_DIV : L_MULT;

    assign w_rs_haz = f_haz(A1_D, TuseRs_D, WriteAddr_E, Tnew_E,
                            WriteAddr_M, Tnew_M);
    assign w_rt_haz = f_haz(A2_D, TuseRt_D, WriteAddr_E, Tnew_E,
                            WriteAddr_M, Tnew_M);
    assign w_md_haz = MDUse_D & (busy | MDStart_E);

    // The flush on Interrupt clears the pipe registers itself.
    assign stall    = (w_rs_haz | w_rt_haz | w_md_haz) & ~Interrupt;
    assign clr      = stall;

    assign busy     = (r_state == S_RUN);
    assign mdCount  = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
        end else if (w_start) begin
            r_state <= S_RUN;
            r_count <= w_load;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
            if (r_count == 4'd1) begin
                r_state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: directed vectors push expectations,
// an independent monitor pops and compares them.
module tb_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       Interrupt;
    logic [4:0] A1_D, A2_D;
    logic [1:0] TuseRs_D, TuseRt_D;
    logic [4:0] WriteAddr_E, WriteAddr_M;
    logic [1:0] Tnew_E, Tnew_M;
    logic       MDStart_E, MDIsDiv_E, MDUse_D;
    logic       stall, clr, busy;
    logic [3:0] mdCount;

    always #5 clk = ~clk;

    stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .Interrupt(Interrupt),
        .A1_D(A1_D),
        .A2_D(A2_D),
        .TuseRs_D(TuseRs_D),
        .TuseRt_D(TuseRt_D),
        .WriteAddr_E(WriteAddr_E),
        .Tnew_E(Tnew_E),
        .WriteAddr_M(WriteAddr_M),
        .Tnew_M(Tnew_M),
        .MDStart_E(MDStart_E),
        .MDIsDiv_E(MDIsDiv_E),
        .MDUse_D(MDUse_D),
        .stall(stall),
        .clr(clr),
        .busy(busy),
        .mdCount(mdCount)
    );

    typedef struct {
        string      name;
        logic       st;
        logic       bz;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic expect_out(input string n, input logic st,
                              input logic bz, input logic [3:0] c);
        exp_t x;
        x.name = n;
        x.st   = st;
        x.bz   = bz;
        x.cnt  = c;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        Interrupt   = 1'b0;
        A1_D        = 5'd0;
        A2_D        = 5'd0;
        TuseRs_D    = 2'd3;
        TuseRt_D    = 2'd3;
        WriteAddr_E = 5'd0;
        Tnew_E      = 2'd0;
        WriteAddr_M = 5'd0;
        Tnew_M      = 2'd0;
        MDStart_E   = 1'b0;
        MDIsDiv_E   = 1'b0;
        MDUse_D     = 1'b0;
    endtask

    // Monitor: settle briefly after each expectation, then compare.
    initial begin
        forever begin
            wait (q.size() > 0);
            #2;
            e = q.pop_front();
            checks++;
            if (stall !== e.st || clr !== e.st ||
                busy !== e.bz || mdCount !== e.cnt) begin
                errors++;
                $display("FAIL %s: got stall=%b clr=%b busy=%b mdCount=%0d, want stall=clr=%b busy=%b mdCount=%0d",
                         e.name, stall, clr, busy, mdCount,
                         e.st, e.bz, e.cnt);
            end
        end
    end

    initial begin
        idle_in();
        reset = 1'b0;
        expect_out("reset_state", 1'b0, 1'b0, 4'd0);
        #3;
        A1_D        = 5'd8;
        TuseRs_D    = 2'd0;
        WriteAddr_E = 5'd8;
        Tnew_E      = 2'd2;
        expect_out("reset_reg_haz", 1'b1, 1'b0, 4'd0);
        tick();
        reset = 1'b1;

        // rs load-use, stall releases as Tnew drains
        expect_out("rs_loaduse_E", 1'b1, 1'b0, 4'd0);
        tick();
        WriteAddr_E = 5'd9;
        Tnew_E      = 2'd0;
        WriteAddr_M = 5'd8;
        Tnew_M      = 2'd1;
        expect_out("rs_loaduse_M1", 1'b1, 1'b0, 4'd0);
        tick();
        Tnew_M = 2'd0;
        expect_out("rs_loaduse_M0", 1'b0, 1'b0, 4'd0);
        tick();

        // rt hazard and equal Tuse/Tnew forwarded
        idle_in();
        A2_D        = 5'd5;
        TuseRt_D    = 2'd1;
        WriteAddr_E = 5'd5;
        Tnew_E      = 2'd2;
        expect_out("rt_haz", 1'b1, 1'b0, 4'd0);
        tick();
        Tnew_E = 2'd1;
        expect_out("rt_equal_fwd", 1'b0, 1'b0, 4'd0);
        tick();

        // $0 and unused operand
        idle_in();
        TuseRs_D = 2'd0;
        Tnew_E   = 2'd2;
        expect_out("reg0_nostall", 1'b0, 1'b0, 4'd0);
        tick();
        idle_in();
        A2_D        = 5'd5;
        WriteAddr_E = 5'd5;
        Tnew_E      = 2'd2;
        expect_out("rt_unused", 1'b0, 1'b0, 4'd0);
        tick();

        // mult followed by mflo: N+1 stall cycles
        idle_in();
        MDStart_E = 1'b1;
        MDUse_D   = 1'b1;
        expect_out("mult_start", 1'b1, 1'b0, 4'd0);
        tick();
        MDStart_E = 1'b0;
        for (int i = 5; i >= 1; i--) begin
            expect_out("mult_busy", 1'b1, 1'b1, 4'(i));
            tick();
        end
        expect_out("mult_done", 1'b0, 1'b0, 4'd0);
        tick();

        // full divide: exactly 10 busy cycles
        idle_in();
        MDStart_E = 1'b1;
        MDIsDiv_E = 1'b1;
        expect_out("div_start", 1'b0, 1'b0, 4'd0);
        tick();
        MDStart_E = 1'b0;
        for (int i = 10; i >= 1; i--) begin
            expect_out("div_busy", 1'b0, 1'b1, 4'(i));
            tick();
        end
        expect_out("div_done", 1'b0, 1'b0, 4'd0);
        tick();

        // divide reloaded by a mult at count 4
        MDStart_E = 1'b1;
        MDIsDiv_E = 1'b1;
        tick();
        MDStart_E = 1'b0;
        for (int i = 10; i >= 5; i--) begin
            expect_out("reload_pre", 1'b0, 1'b1, 4'(i));
            tick();
        end
        MDStart_E = 1'b1;
        MDIsDiv_E = 1'b0;
        expect_out("reload_at4", 1'b0, 1'b1, 4'd4);
        tick();
        MDStart_E = 1'b0;
        for (int i = 5; i >= 1; i--) begin
            expect_out("reload_busy", 1'b0, 1'b1, 4'(i));
            tick();
        end
        expect_out("reload_done", 1'b0, 1'b0, 4'd0);
        tick();

        // Interrupt masks stall and blocks a same-cycle start
        idle_in();
        A1_D        = 5'd8;
        TuseRs_D    = 2'd0;
        WriteAddr_E = 5'd8;
        Tnew_E      = 2'd2;
        Interrupt   = 1'b1;
        MDStart_E   = 1'b1;
        MDUse_D     = 1'b1;
        expect_out("irq_haz_mask", 1'b0, 1'b0, 4'd0);
        tick();
        idle_in();
        expect_out("irq_nostart", 1'b0, 1'b0, 4'd0);
        tick();
        MDStart_E = 1'b1;
        MDIsDiv_E = 1'b1;
        tick();
        MDStart_E = 1'b0;
        for (int i = 10; i >= 8; i--) begin
            expect_out("irq_pre", 1'b0, 1'b1, 4'(i));
            tick();
        end
        Interrupt = 1'b1;
        MDStart_E = 1'b1;
        MDIsDiv_E = 1'b0;
        MDUse_D   = 1'b1;
        expect_out("irq_run7", 1'b0, 1'b1, 4'd7);
        tick();
        idle_in();
        expect_out("irq_cont6", 1'b0, 1'b1, 4'd6);
        tick();
        repeat (6) tick();
        expect_out("irq_drained", 1'b0, 1'b0, 4'd0);
        tick();

        // async reset mid-period at count 3
        MDStart_E = 1'b1;
        tick();
        MDStart_E = 1'b0;
        tick();
        tick();
        expect_out("pre_reset3", 1'b0, 1'b1, 4'd3);
        #3;
        reset = 1'b0;
        expect_out("async_reset", 1'b0, 1'b0, 4'd0);
        tick();
        expect_out("reset_held", 1'b0, 1'b0, 4'd0);
        reset   = 1'b1;
        MDUse_D = 1'b1;
        #3;
        expect_out("post_reset_md", 1'b0, 1'b0, 4'd0);
        tick();
        expect_out("post_reset_md2", 1'b0, 1'b0, 4'd0);
        tick();

        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
